// File: rtl/deserializer_sipo.sv
// ============================================================================
// Module  : deserializer_sipo
// Brief   : Serial-in/parallel-out receiver with valid/ack word handshake.
//           Optional even-parity bit per word when PARITY_CHECK_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module deserializer_sipo #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serial_in,
    input  logic                  shift,
    input  logic                  TX_active,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ack,
    output logic                  busy,
    output logic                  frame_err,
`ifdef PARITY_CHECK_EN
    output logic                  parity_err,
`endif
    output logic                  overrun
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RECV = 1'b1;

`ifdef PARITY_CHECK_EN
    localparam int c_TC = DATA_WIDTH + 1;
`else
    localparam int c_TC = DATA_WIDTH;
`endif
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(c_TC - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [0:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_sr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_frame_err;
    logic                  r_overrun;

    logic                  w_bit_q;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_bit_q = shift & TX_active;
    assign w_done  = (r_state == c_RECV) && w_bit_q && (r_cnt == c_LAST);

`ifdef PARITY_CHECK_EN
    // The final qualified bit is parity; the data bits are already in r_sr.
    logic r_parity_err;
    logic w_perr;
    assign w_word     = r_sr;
    assign w_perr     = (^r_sr) ^ serial_in;
    assign parity_err = r_parity_err;
`else
    assign w_word = {r_sr[DATA_WIDTH-2:0], serial_in};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_sr        <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (w_bit_q) begin
                        r_sr    <= {r_sr[DATA_WIDTH-2:0], serial_in};
                        r_cnt   <= c_ONE;
                        r_busy  <= 1'b1;
                        r_state <= c_RECV;
                    end
                end
                c_RECV: begin
                    if (!TX_active) begin
                        r_frame_err <= (r_cnt != '0);
                        r_cnt       <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= c_IDLE;
                    end else if (shift) begin
`ifdef PARITY_CHECK_EN
                        if (!w_done) begin
                            r_sr <= {r_sr[DATA_WIDTH-2:0], serial_in};
                        end
`else
                        r_sr <= {r_sr[DATA_WIDTH-2:0], serial_in};
`endif
                        if (w_done) begin
                            r_cnt  <= '0;
                            r_busy <= 1'b0;
                        end else begin
                            r_cnt  <= r_cnt + c_ONE;
                            r_busy <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase

            // An ack in the completion cycle frees the slot for the new word.
            if (w_done) begin
`ifdef PARITY_CHECK_EN
                r_parity_err <= w_perr;
`endif
                if (!r_valid || data_ack) begin
                    r_data  <= w_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (data_ack && r_valid) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign busy       = r_busy;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire
